// File: rtl/rr_mux_arbiter.sv
// Round-robin N-to-1 mux with one registered output stage.
// Define RR_MUX_ARBITER_PACKET_LOCK_EN to hold the grant until a channel's last beat.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;

  logic          found;
  logic [SW-1:0] gnt;
  logic [SW-1:0] gnt_nxt;
  logic          load;
  logic          accept;
  int            idx;

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
`endif

  assign load   = !valid_q | out_ready;
  assign accept = load & found & !rst;

  // Rotating scan starting at ptr; a held lock overrides the scan.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt   = SW'(idx);
      end
    end
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    if (lock_q) begin
      found = in_valid[lock_ch_q];
      gnt   = lock_ch_q;
    end
`endif
  end

  assign gnt_nxt = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data[int'(gnt)*W +: W];
      sel_d   = gnt;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      if (in_last[gnt]) begin
        lock_d = 1'b0;
        ptr_d  = gnt_nxt;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = gnt;
      end
`else
      ptr_d = gnt_nxt;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sel_q     <= '0;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8).
// Lock scenarios run when RR_MUX_ARBITER_PACKET_LOCK_EN is defined.
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic [7:0]  din [4];
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
  logic [3:0]  in_last;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  assign in_data = {din[3], din[2], din[1], din[0]};

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel,
                         input logic [7:0] data);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sel"}, 32'(out_sel), 32'(sel));
    chk({tag, ".data"}, 32'(out_data), 32'(data));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'hA0 + 8'(i);
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    in_last = 4'b1111;
`endif
    step();
    step();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.sel", 32'(out_sel), 32'd0);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rst.ready", 32'(in_ready), 32'd0);

    // Round robin, all valid
    rst = 1'b0;
    #1;
    chk("rr.ready0", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("rr%0d", i), 2'(i % 4), 8'hA0 + 8'(i % 4));
      chk($sformatf("rr%0d.ready", i), 32'(in_ready),
          32'(4'b0001 << ((i + 1) % 4)));
    end
    in_valid = '0;
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Stall with only ch2 valid
    in_valid  = 4'b0100;
    din[2]    = 8'h5C;
    out_ready = 1'b0;
    #1;
    chk("stall.ready_in", 32'(in_ready), 32'b0100);
    step();
    chk_out("stall.load", 2'd2, 8'h5C);
    din[2] = 8'h5D;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d.ready", i), 32'(in_ready), 32'd0);
      step();
      chk_out($sformatf("stall%0d", i), 2'd2, 8'h5C);
    end
    out_ready = 1'b1;
    #1;
    chk("stall.release_ready", 32'(in_ready), 32'b0100);
    step();
    chk_out("stall.next", 2'd2, 8'h5D);

    // Wrap from ptr=3
    in_valid = 4'b0101;
    din[0]   = 8'h10;
    din[2]   = 8'h12;
    #1;
    chk("wrap.ready0", 32'(in_ready), 32'b0001);
    step();
    chk_out("wrap.g0", 2'd0, 8'h10);
    chk("wrap.ready2", 32'(in_ready), 32'b0100);
    step();
    chk_out("wrap.g2", 2'd2, 8'h12);

    // Reset with beat held
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.data", 32'(out_data), 32'd0);
    chk("mrst.sel", 32'(out_sel), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) din[i] = 8'hA0 + 8'(i);
    #1;
    chk("mrst.ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("mrst.g0", 2'd0, 8'hA0);
    in_valid = '0;
    #1;
    chk("idle.ready", 32'(in_ready), 32'd0);
    step();
    chk("idle.valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0001;
    #1;
    chk("idle.ptr_kept", 32'(in_ready), 32'b0001);
    in_valid = '0;

`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    // ptr=1: ch1 three-beat packet while ch0/ch2 wait
    in_valid   = 4'b0111;
    in_last    = 4'b1101;
    din[1]     = 8'hB0;
    #1;
    chk("lk.ready_a", 32'(in_ready), 32'b0010);
    step();
    chk_out("lk.b0", 2'd1, 8'hB0);
    din[1] = 8'hB1;
    #1;
    chk("lk.ready_b", 32'(in_ready), 32'b0010);
    step();
    chk_out("lk.b1", 2'd1, 8'hB1);
    din[1]     = 8'hB2;
    in_last[1] = 1'b1;
    step();
    chk_out("lk.b2", 2'd1, 8'hB2);
    step();
    chk_out("lk.ch2", 2'd2, 8'hA2);
    step();
    chk_out("lk.ch0", 2'd0, 8'hA0);
    in_valid = '0;
    step();

    // ch1 pauses mid-packet, ch0 must not win
    in_valid   = 4'b0011;
    in_last[1] = 1'b0;
    din[1]     = 8'hC0;
    step();
    chk_out("gap.c0", 2'd1, 8'hC0);
    in_valid = 4'b0001;
    #1;
    chk("gap.ready0", 32'(in_ready), 32'd0);
    step();
    chk("gap.valid0", 32'(out_valid), 32'd0);
    chk("gap.ready1", 32'(in_ready), 32'd0);
    step();
    chk("gap.valid1", 32'(out_valid), 32'd0);
    in_valid   = 4'b0011;
    in_last[1] = 1'b1;
    din[1]     = 8'hC1;
    #1;
    chk("gap.resume", 32'(in_ready), 32'b0010);
    step();
    chk_out("gap.c1", 2'd1, 8'hC1);
    in_valid = 4'b0001;
    #1;
    chk("gap.unlock", 32'(in_ready), 32'b0001);
    in_valid = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8, data width per channel in bits; legal range 1..64.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  N  bit i set = channel i offers a beat.
REQ-006 in_data  input  N*W  channel i data in bits [i*W +: W].
REQ-007 in_ready  output  N  bit i set = channel i beat is accepted this cycle (in_valid[i] & in_ready[i]).
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  W  data of held beat.
REQ-010 out_sel  output  $clog2(N)  source channel index of held beat.
REQ-011 out_ready  input  1  downstream accepts held beat this cycle (out_valid & out_ready).

Function
REQ-012 Block SHALL be an N-to-1 multiplexer with round-robin channel selection and a single registered output stage.
REQ-013 load = !out_valid | out_ready; a beat SHALL be accepted only when load is 1.
REQ-014 Grant SHALL go to the first channel with in_valid set, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-015 At most one in_ready bit SHALL be set per cycle; in_ready[g] = load & in_valid[g] for granted g; all others 0.
REQ-016 in_ready SHALL depend only on in_valid, out_ready and internal state, never on in_data.
REQ-017 On acceptance from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N.
REQ-018 Latency SHALL be 1 cycle, input acceptance to out_valid; throughput 1 beat/cycle when out_ready held high.
REQ-019 Drain with no new acceptance (out_ready=1, no in_valid): out_valid <= 0 next cycle; ptr unchanged.
REQ-020 While out_valid=1 and out_ready=0: out_data, out_sel SHALL hold stable; in_ready SHALL be all 0.
REQ-021 Simultaneous drain and accept SHALL replace the register contents with no bubble.
REQ-022 No in_valid set: no grant, ptr unchanged.
REQ-023 ptr wrap: grant to N-1 SHALL set ptr to 0.
REQ-024 No beat SHALL be duplicated or dropped outside reset.

Reset
REQ-025 On rst=1 at a clock edge: out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-026 in_ready SHALL be all 0 during any cycle with rst=1.
REQ-027 Reset mid-operation SHALL discard the held beat and any packet lock.

Configuration
REQ-028 Macro RR_MUX_ARBITER_PACKET_LOCK_EN SHALL compile packet locking in or out.
REQ-029 Defined: extra port in_last  input  N, bit i = channel i beat is last of packet.
REQ-030 Defined: accepting a beat from g with in_last[g]=0 SHALL lock grant to g; other channels get no in_ready until a beat with in_last[g]=1 from g is accepted.
REQ-031 Defined: ptr SHALL advance to (g+1) mod N only on acceptance of a last beat; lock cleared in the same cycle.
REQ-032 Not defined: in_last port absent; every beat is a complete packet; REQ-017 applies unchanged.

Verification
REQ-033 N=4, W=8, all in_valid=1, data ch i = 8'hA0+i, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
REQ-034 Only ch2 valid, data 8'h5C, out_ready=0 for 3 cycles -> out_valid=1, out_data=5C stable, in_ready=0000 for those cycles; out_ready=1 -> one transfer, ch2 accepted again next.
REQ-035 ptr=3 (after grant to ch2), in_valid=4'b0101 -> grant ch0 (wrap), then ch2.
REQ-036 Beat held (out_valid=1), rst=1 for one cycle -> out_valid=0, out_data=0, out_sel=0; next grant with all valid is ch0.
REQ-037 Lock EN, ch1 sends 3 beats in_last=0,0,1 while ch0, ch2 valid -> out_sel 1,1,1, then 2, then 0.
REQ-038 Lock EN, ch1 in_last=0 beat accepted, ch1 in_valid drops 2 cycles with ch0 valid -> no grant, out_valid=0 after drain; ch1 resumes and continues packet.
